// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: scene encoding,
// keycodes, winner colours and a layer geometry record.
package sprite_pkg;

  typedef enum logic [1:0] {
    SCENE_TITLE     = 2'b00,
    SCENE_OVERWORLD = 2'b01,
    SCENE_BATTLE    = 2'b10,
    SCENE_RESULT    = 2'b11
  } scene_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_1     = 8'h1E;
  localparam logic [7:0] KEY_2     = 8'h1F;
  localparam logic [7:0] KEY_3     = 8'h20;

  localparam logic [1:0] WIN_RED   = 2'b00;
  localparam logic [1:0] WIN_BLUE  = 2'b01;
  localparam logic [1:0] WIN_NONE  = 2'b10;
  localparam logic [1:0] WIN_GREEN = 2'b11;

  localparam logic [23:0] RGB_RED   = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE  = 24'h0000FF;
  localparam logic [23:0] RGB_GREEN = 24'h00FF00;

  localparam int GEOM_W = 10;

  typedef struct packed {
    logic [GEOM_W-1:0] x;
    logic [GEOM_W-1:0] y;
    logic [GEOM_W-1:0] w;
    logic [GEOM_W-1:0] h;
  } layer_geom_t;

  function automatic logic [23:0] winnerRgb(input logic [1:0] win);
    case (win)
      WIN_RED:   return RGB_RED;
      WIN_BLUE:  return RGB_BLUE;
      WIN_GREEN: return RGB_GREEN;
      default:   return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/sprite_layer_hit.sv
// One layer's rectangle hit test and ROM address generation, registered
// so the address reaches the external ROM at the end of the first stage.
module sprite_layer_hit #(
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 12
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [COORD_W-1:0] drawX_i,
  input  logic [COORD_W-1:0] drawY_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] w_i,
  input  logic [COORD_W-1:0] h_i,
  input  logic               en_i,
  output logic               hit_o,
  output logic [ADDR_W-1:0]  addr_o
);

  localparam int PROD_W = (2*COORD_W > ADDR_W) ? 2*COORD_W : ADDR_W;

  logic [COORD_W:0]   xEnd;
  logic [COORD_W:0]   yEnd;
  logic               inX;
  logic               inY;
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic [PROD_W-1:0]  offset;
  logic               hit_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               hit_q;
  logic [ADDR_W-1:0]  addr_q;

  // Right/bottom edges carry an extra bit so layers near the coordinate limit never wrap.
  always_comb begin
    xEnd   = {1'b0, x_i} + {1'b0, w_i};
    yEnd   = {1'b0, y_i} + {1'b0, h_i};
    inX    = (drawX_i >= x_i) && ({1'b0, drawX_i} < xEnd);
    inY    = (drawY_i >= y_i) && ({1'b0, drawY_i} < yEnd);
    hit_d  = en_i && inX && inY;
    dx     = drawX_i - x_i;
    dy     = drawY_i - y_i;
    offset = PROD_W'(dy) * PROD_W'(w_i) + PROD_W'(dx);
    addr_d = hit_d ? offset[ADDR_W-1:0] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hit_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      hit_q  <= hit_d;
      addr_q <= addr_d;
    end
  end

  assign hit_o  = hit_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage sprite compositor with palette lookup and a frame-synchronised
// scene state machine that can replace the picture with a winner colour.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int              NUM_LAYERS      = 4,
  parameter int              COORD_W         = 10,
  parameter int              ADDR_W          = 12,
  parameter int              IDX_W           = 6,
  parameter logic [IDX_W-1:0] TRANSPARENT_IDX = '0,
  parameter int              FLASH_FRAMES    = 30
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [COORD_W-1:0]           DrawX_i,
  input  logic [COORD_W-1:0]           DrawY_i,
  input  logic                         frame_start_i,
  input  logic [7:0]                   keycode_i,
  input  logic [1:0]                   winner_i,
  input  logic [NUM_LAYERS*COORD_W-1:0] layer_x_i,
  input  logic [NUM_LAYERS*COORD_W-1:0] layer_y_i,
  input  logic [NUM_LAYERS*COORD_W-1:0] layer_w_i,
  input  logic [NUM_LAYERS*COORD_W-1:0] layer_h_i,
  input  logic [NUM_LAYERS-1:0]        layer_en_i,
  input  logic [IDX_W-1:0]             bg_idx_i,
  output logic [NUM_LAYERS*ADDR_W-1:0] layer_addr_o,
  input  logic [NUM_LAYERS*IDX_W-1:0]  layer_data_i,
  input  logic                         pal_we_i,
  input  logic [IDX_W-1:0]             pal_waddr_i,
  input  logic [23:0]                  pal_wdata_i,
  output logic [1:0]                   scene_o,
  output logic [7:0]                   Red_o,
  output logic [7:0]                   Green_o,
  output logic [7:0]                   Blue_o
);

  localparam int PAL_DEPTH = 2**IDX_W;
  localparam int FLASH_W   = $clog2(FLASH_FRAMES + 1);

  logic [NUM_LAYERS-1:0] hitS0;
  logic [NUM_LAYERS-1:0] hitS1_q;
  logic [IDX_W-1:0]      bgS0_q, bgS1_q;
  logic                  resS0_q, resS1_q;
  logic [1:0]            winS0_q, winS1_q;
  logic [IDX_W-1:0]      selIdx;
  logic [IDX_W-1:0]      layerIdx;
  logic [23:0]           rgb_d, rgb_q;
  logic [23:0]           pal_q [PAL_DEPTH];

  scene_t               scene_q, scene_d;
  logic [7:0]           keyReq_q, keyReq_d;
  logic [7:0]           key;
  logic [1:0]           winner_q, winner_d;
  logic [FLASH_W-1:0]   flash_q, flash_d;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : gLayer
    sprite_layer_hit #(
      .COORD_W(COORD_W),
      .ADDR_W (ADDR_W)
    ) uHit (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .drawX_i(DrawX_i),
      .drawY_i(DrawY_i),
      .x_i    (layer_x_i[g*COORD_W +: COORD_W]),
      .y_i    (layer_y_i[g*COORD_W +: COORD_W]),
      .w_i    (layer_w_i[g*COORD_W +: COORD_W]),
      .h_i    (layer_h_i[g*COORD_W +: COORD_W]),
      .en_i   (layer_en_i[g]),
      .hit_o  (hitS0[g]),
      .addr_o (layer_addr_o[g*ADDR_W +: ADDR_W])
    );
  end

  // The result-screen flag travels with each pixel so the bypass keeps the normal latency.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bgS0_q  <= '0;
      bgS1_q  <= '0;
      hitS1_q <= '0;
      resS0_q <= 1'b0;
      resS1_q <= 1'b0;
      winS0_q <= '0;
      winS1_q <= '0;
      rgb_q   <= '0;
    end else begin
      bgS0_q  <= bg_idx_i;
      bgS1_q  <= bgS0_q;
      hitS1_q <= hitS0;
      resS0_q <= (scene_q == SCENE_RESULT);
      resS1_q <= resS0_q;
      winS0_q <= winner_q;
      winS1_q <= winS0_q;
      rgb_q   <= rgb_d;
    end
  end

  // Scanning from the last layer down lets the lowest-numbered opaque layer win.
  always_comb begin
    selIdx   = bgS1_q;
    layerIdx = '0;
    for (int i = NUM_LAYERS-1; i >= 0; i--) begin
      layerIdx = layer_data_i[i*IDX_W +: IDX_W];
      if (hitS1_q[i] && (layerIdx != TRANSPARENT_IDX)) selIdx = layerIdx;
    end
    rgb_d = resS1_q ? winnerRgb(winS1_q) : pal_q[selIdx];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < PAL_DEPTH; k++) pal_q[k] <= '0;
    end else if (pal_we_i) begin
      pal_q[pal_waddr_i] <= pal_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scene_q  <= SCENE_TITLE;
      keyReq_q <= '0;
      winner_q <= '0;
      flash_q  <= '0;
    end else begin
      scene_q  <= scene_d;
      keyReq_q <= keyReq_d;
      winner_q <= winner_d;
      flash_q  <= flash_d;
    end
  end

  // A key arriving together with frame_start takes precedence over the pending one.
  always_comb begin
    scene_d  = scene_q;
    keyReq_d = keyReq_q;
    winner_d = winner_q;
    flash_d  = flash_q;
    key      = (keycode_i != 8'h00) ? keycode_i : keyReq_q;
    if (keycode_i != 8'h00) keyReq_d = keycode_i;
    if (frame_start_i) begin
      keyReq_d = '0;
      if (scene_q == SCENE_RESULT) begin
        if (flash_q == '0) scene_d = SCENE_OVERWORLD;
        else               flash_d = flash_q - FLASH_W'(1);
      end else if (key == KEY_1) begin
        scene_d = SCENE_TITLE;
      end else if (key == KEY_2) begin
        scene_d = SCENE_OVERWORLD;
      end else if (key == KEY_3) begin
        scene_d = SCENE_BATTLE;
      end else begin
        case (scene_q)
          SCENE_TITLE:     if (key == KEY_ENTER) scene_d = SCENE_OVERWORLD;
          SCENE_OVERWORLD: if (key == KEY_ENTER) scene_d = SCENE_BATTLE;
          SCENE_BATTLE: begin
            if ((key == KEY_SPACE) && (winner_i != WIN_NONE)) begin
              scene_d  = SCENE_RESULT;
              winner_d = winner_i;
              flash_d  = FLASH_W'(FLASH_FRAMES - 1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign scene_o = scene_q;
  assign {Red_o, Green_o, Blue_o} = rgb_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: a reference pixel model predicts
// RGB three cycles ahead while directed sequences walk the scene machine.
module tb_sprite_compositor;
  import sprite_pkg::*;

  localparam int NL = 4;
  localparam int CW = 10;
  localparam int AW = 12;
  localparam int IW = 6;
  localparam int FF = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [CW-1:0]     drawX, drawY;
  logic              frameStart;
  logic [7:0]        keycode;
  logic [1:0]        winner;
  logic [NL*CW-1:0]  layerX, layerY, layerW, layerH;
  logic [NL-1:0]     layerEn;
  logic [IW-1:0]     bgIdx;
  logic [NL*AW-1:0]  layerAddr;
  logic [NL*IW-1:0]  layerData;
  logic              palWe;
  logic [IW-1:0]     palWaddr;
  logic [23:0]       palWdata;
  logic [1:0]        scene;
  logic [7:0]        red, green, blue;

  layer_geom_t geom [NL];
  bit [NL-1:0] forceTransp;

  sprite_compositor #(
    .NUM_LAYERS(NL), .COORD_W(CW), .ADDR_W(AW), .IDX_W(IW),
    .TRANSPARENT_IDX(6'd0), .FLASH_FRAMES(FF)
  ) dut (
    .clk_i(clk), .reset_i(reset), .DrawX_i(drawX), .DrawY_i(drawY),
    .frame_start_i(frameStart), .keycode_i(keycode), .winner_i(winner),
    .layer_x_i(layerX), .layer_y_i(layerY), .layer_w_i(layerW), .layer_h_i(layerH),
    .layer_en_i(layerEn), .bg_idx_i(bgIdx), .layer_addr_o(layerAddr),
    .layer_data_i(layerData), .pal_we_i(palWe), .pal_waddr_i(palWaddr),
    .pal_wdata_i(palWdata), .scene_o(scene), .Red_o(red), .Green_o(green), .Blue_o(blue)
  );

  for (genvar g = 0; g < NL; g++) begin : gGeom
    assign layerX[g*CW +: CW] = geom[g].x;
    assign layerY[g*CW +: CW] = geom[g].y;
    assign layerW[g*CW +: CW] = geom[g].w;
    assign layerH[g*CW +: CW] = geom[g].h;
  end

  function automatic logic [IW-1:0] romFn(input int i, input logic [AW-1:0] a);
    if (forceTransp[i]) return '0;
    return IW'((int'(a) * 5 + i * 17 + 9) % 64);
  endfunction

  // External per-layer ROMs: data follows the address by one clock.
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) layerData[i*IW +: IW] <= romFn(i, layerAddr[i*AW +: AW]);
  end

  int unsigned cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  typedef struct {
    int unsigned due;
    logic [23:0] rgb;
  } exp_t;
  exp_t sbq [$];

  int checks = 0;
  int passes = 0;

  logic [23:0] palModel [64];
  logic        pendValid;
  int          pendAddr;
  logic [23:0] pendData;
  int unsigned pendCycle;
  scene_t      sceneModel;
  logic [1:0]  winModel;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cnt);
  endtask

  function automatic logic [23:0] palAt(input int idx, input int unsigned rc);
    if (pendValid && idx == pendAddr && rc >= pendCycle) return pendData;
    return palModel[idx];
  endfunction

  function automatic logic [23:0] refPixel(input int x, input int y, input int unsigned rc);
    int idx;
    int gx, gy, gw, gh;
    logic [IW-1:0] d;
    if (sceneModel == SCENE_RESULT) begin
      case (winModel)
        2'b00:   return 24'hFF0000;
        2'b01:   return 24'h0000FF;
        2'b11:   return 24'h00FF00;
        default: return 24'h000000;
      endcase
    end
    idx = int'(bgIdx);
    for (int i = 0; i < NL; i++) begin
      gx = int'(geom[i].x); gy = int'(geom[i].y);
      gw = int'(geom[i].w); gh = int'(geom[i].h);
      if (layerEn[i] && x >= gx && x < gx + gw && y >= gy && y < gy + gh) begin
        d = romFn(i, AW'(((y - gy) * gw + (x - gx)) % 4096));
        if (d != 0) begin
          idx = int'(d);
          break;
        end
      end
    end
    return palAt(idx, rc);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      if (sbq[0].due == cnt) begin
        e = sbq.pop_front();
        checkOutput("rgb", {8'h00, red, green, blue}, {8'h00, e.rgb});
      end else if (sbq[0].due < cnt) begin
        checkOutput("rgbMissed", cnt, sbq[0].due);
        e = sbq.pop_front();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int x, input int y);
    exp_t e;
    drawX = CW'(x);
    drawY = CW'(y);
    e.due = cnt + 3;
    e.rgb = refPixel(x, y, cnt + 2);
    sbq.push_back(e);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("drainTimeout", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic writePal(input int a, input logic [23:0] d);
    palWe = 1'b1; palWaddr = IW'(a); palWdata = d;
    tick();
    palWe = 1'b0;
    palModel[a] = d;
  endtask

  task automatic setGeom(input int i, input int x, input int y, input int w, input int h);
    geom[i].x = CW'(x); geom[i].y = CW'(y); geom[i].w = CW'(w); geom[i].h = CW'(h);
  endtask

  task automatic pulseKey(input logic [7:0] k);
    keycode = k;
    tick();
    keycode = 8'h00;
  endtask

  task automatic pulseFrame();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
  endtask

  task automatic randomStream(input int n);
    for (int k = 0; k < n; k++) begin
      layerEn = NL'($urandom);
      bgIdx   = IW'($urandom);
      applyStimulus(int'($urandom_range(0, 270)), int'($urandom_range(0, 270)));
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; drawX = '0; drawY = '0; frameStart = 1'b0; keycode = 8'h00;
    winner = 2'b10; layerEn = '0; bgIdx = '0; palWe = 1'b0; palWaddr = '0; palWdata = '0;
    forceTransp = '0; pendValid = 1'b0; pendAddr = 0; pendData = '0; pendCycle = 0;
    sceneModel = SCENE_TITLE; winModel = 2'b00;
    for (int i = 0; i < NL; i++) setGeom(i, 0, 0, 0, 0);
    for (int a = 0; a < 64; a++) palModel[a] = '0;
    tick(); tick(); tick();
    checkOutput("resetScene", {30'd0, scene}, 32'(SCENE_TITLE));
    checkOutput("resetRgb", {8'h00, red, green, blue}, 32'h0);
    checkOutput("resetAddr", 32'(layerAddr[31:0]), 32'h0);
    reset = 1'b0;
    tick();

    $display("[TB] background-only palette entry 5");
    writePal(5, 24'h123456);
    bgIdx = 6'd5; layerEn = '0;
    for (int k = 0; k < 6; k++) applyStimulus(k * 37, 20 + k);
    drain();

    for (int a = 0; a < 64; a++) if (a != 5) writePal(a, 24'($urandom));

    $display("[TB] palette write during read of the same entry");
    bgIdx = 6'd5; layerEn = '0;
    pendAddr = 5; pendData = 24'hABCDEF; pendCycle = cnt + 4; pendValid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      palWe = (k == 3); palWaddr = 6'd5; palWdata = pendData;
      applyStimulus(k * 10, 7);
    end
    palWe = 1'b0;
    drain();
    palModel[5] = pendData; pendValid = 1'b0;

    $display("[TB] overlapping layers and priority");
    setGeom(0, 100, 100, 20, 20);
    setGeom(1, 105, 100, 20, 20);
    layerEn = 4'b0011; bgIdx = 6'd5;
    applyStimulus(110, 105);
    checkOutput("addr0", 32'(layerAddr[0*AW +: AW]), 32'd110);
    checkOutput("addr1", 32'(layerAddr[1*AW +: AW]), 32'd105);
    applyStimulus(102, 101);
    applyStimulus(122, 119);
    drain();
    forceTransp = 4'b0001;
    applyStimulus(110, 105);
    applyStimulus(102, 101);
    drain();
    forceTransp = '0;

    $display("[TB] edge and wrap boundaries");
    setGeom(0, 620, 0, 30, 480);
    setGeom(1, 1000, 0, 30, 10);
    setGeom(2, 0, 0, 0, 10);
    layerEn = 4'b0111; bgIdx = 6'd5;
    applyStimulus(639, 1);
    checkOutput("edgeHit639", 32'(layerAddr[0*AW +: AW]), 32'd49);
    applyStimulus(619, 1);
    checkOutput("edgeMiss619", 32'(layerAddr[0*AW +: AW]), 32'd0);
    applyStimulus(649, 2);
    checkOutput("edgeHit649", 32'(layerAddr[0*AW +: AW]), 32'd89);
    applyStimulus(1020, 2);
    checkOutput("noWrapHit", 32'(layerAddr[1*AW +: AW]), 32'd80);
    applyStimulus(5, 2);
    checkOutput("noWrapMiss", 32'(layerAddr[1*AW +: AW]), 32'd0);
    applyStimulus(3, 3);
    checkOutput("zeroWidth", 32'(layerAddr[2*AW +: AW]), 32'd0);
    drain();

    $display("[TB] randomized compositing");
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < NL; i++)
        setGeom(i, int'($urandom_range(0, 200)), int'($urandom_range(0, 200)),
                int'($urandom_range(0, 60)), int'($urandom_range(0, 60)));
      randomStream(40);
    end

    $display("[TB] scene machine");
    checkOutput("titleIdle", {30'd0, scene}, 32'(SCENE_TITLE));
    pulseKey(KEY_3);
    pulseKey(KEY_ENTER);
    tick(); tick();
    checkOutput("titleHold", {30'd0, scene}, 32'(SCENE_TITLE));
    frameStart = 1'b1;
    checkOutput("titleDuringFrame", {30'd0, scene}, 32'(SCENE_TITLE));
    tick();
    frameStart = 1'b0;
    checkOutput("titleToOverworld", {30'd0, scene}, 32'(SCENE_OVERWORLD));
    sceneModel = SCENE_OVERWORLD;
    randomStream(10);

    pulseKey(KEY_1);
    keycode = KEY_ENTER;
    pulseFrame();
    keycode = 8'h00;
    checkOutput("newKeyWins", {30'd0, scene}, 32'(SCENE_BATTLE));

    winner = 2'b10;
    pulseKey(KEY_SPACE);
    pulseFrame();
    checkOutput("noWinnerStays", {30'd0, scene}, 32'(SCENE_BATTLE));

    pulseKey(KEY_2);
    pulseFrame();
    checkOutput("debugOverworld", {30'd0, scene}, 32'(SCENE_OVERWORLD));
    pulseKey(KEY_ENTER);
    pulseFrame();
    checkOutput("overworldToBattle", {30'd0, scene}, 32'(SCENE_BATTLE));

    $display("[TB] result screen");
    winner = 2'b01;
    pulseKey(KEY_SPACE);
    pulseFrame();
    checkOutput("battleToResult", {30'd0, scene}, 32'(SCENE_RESULT));
    sceneModel = SCENE_RESULT; winModel = 2'b01;
    winner = 2'b00;
    randomStream(8);
    pulseKey(KEY_1);
    for (int k = 1; k <= FF; k++) begin
      pulseFrame();
      if (k < FF) checkOutput("resultHeld", {30'd0, scene}, 32'(SCENE_RESULT));
      if (k == 15) randomStream(4);
    end
    checkOutput("resultToOverworld", {30'd0, scene}, 32'(SCENE_OVERWORLD));
    sceneModel = SCENE_OVERWORLD;
    randomStream(10);

    $display("[TB] reset during result");
    pulseKey(KEY_ENTER);
    pulseFrame();
    checkOutput("againBattle", {30'd0, scene}, 32'(SCENE_BATTLE));
    winner = 2'b00;
    pulseKey(KEY_SPACE);
    pulseFrame();
    checkOutput("againResult", {30'd0, scene}, 32'(SCENE_RESULT));
    sceneModel = SCENE_RESULT; winModel = 2'b00;
    randomStream(4);
    reset = 1'b1;
    tick();
    checkOutput("midResetScene", {30'd0, scene}, 32'(SCENE_TITLE));
    checkOutput("midResetRgb", {8'h00, red, green, blue}, 32'h0);
    checkOutput("midResetAddr", 32'(layerAddr[31:0]) | 32'(layerAddr[NL*AW-1:32]), 32'h0);
    reset = 1'b0;
    sceneModel = SCENE_TITLE;
    for (int a = 0; a < 64; a++) palModel[a] = '0;
    tick();
    for (int k = 0; k <= FF; k++) pulseFrame();
    checkOutput("titleAfterReset", {30'd0, scene}, 32'(SCENE_TITLE));
    randomStream(10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
